// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low abcdefg patterns and special BCD codes.
// Used by both the display decoder and the scan reader.
package seg7_pkg;

    localparam int unsigned SEG_W  = 7;
    localparam int unsigned CODE_W = 4;

    localparam logic [0:SEG_W-1] SEG_0     = 7'b0000001;
    localparam logic [0:SEG_W-1] SEG_1     = 7'b1001111;
    localparam logic [0:SEG_W-1] SEG_2     = 7'b0010010;
    localparam logic [0:SEG_W-1] SEG_3     = 7'b0000110;
    localparam logic [0:SEG_W-1] SEG_4     = 7'b1001100;
    localparam logic [0:SEG_W-1] SEG_5     = 7'b0100100;
    localparam logic [0:SEG_W-1] SEG_6     = 7'b0100000;
    localparam logic [0:SEG_W-1] SEG_7     = 7'b0001111;
    localparam logic [0:SEG_W-1] SEG_8     = 7'b0000000;
    localparam logic [0:SEG_W-1] SEG_9     = 7'b0000100;
    localparam logic [0:SEG_W-1] SEG_BLANK = 7'b1111111;

    localparam logic [CODE_W-1:0] CODE_BLANK = 4'hF;
    localparam logic [CODE_W-1:0] CODE_ERR   = 4'hE;

endpackage

// File: rtl/seg7_pattern_to_bcd.sv
// Combinational inverse of the segment decoder: pattern -> BCD code with blank/error flags.
module seg7_pattern_to_bcd
    import seg7_pkg::*;
(
    input  logic [0:SEG_W-1]  seg,
    output logic [CODE_W-1:0] code,
    output logic              blank,
    output logic              err
);

    always_comb begin
        code  = CODE_ERR;
        blank = 1'b0;
        err   = 1'b0;
        unique case (seg)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_BLANK: begin
                code  = CODE_BLANK;
                blank = 1'b1;
            end
            default:   err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Recovers a 4-digit BCD word from a multiplexed active-low 7-segment bus,
// capturing each slot after it has been stable, and hands frames out on valid/ready.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [0:SEG_W-1]  seg,
    input  logic [3:0]        an,
    output logic [15:0]       bcd_out,
    output logic [3:0]        blank_mask,
    output logic [3:0]        err_mask,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun
);

    localparam int unsigned     CNT_W      = 8;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] STABLE_THR = CNT_W'(STABLE_CYCLES);

    logic [0:SEG_W-1]  samp_seg;
    logic [3:0]        samp_an;
    logic [CNT_W-1:0]  cnt;
    logic              armed;
    logic [3:0]        cap_mask;
    logic [15:0]       slot_bcd;
    logic [3:0]        slot_blank;
    logic [3:0]        slot_err;

    logic              an_ok;
    logic [1:0]        an_idx;
    logic              same;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              fire;
    logic              frame_load;
    logic [3:0]        cap_mask_nxt;

    logic [CODE_W-1:0] dec_code;
    logic              dec_blank;
    logic              dec_err;

    seg7_pattern_to_bcd u_dec (
        .seg   (samp_seg),
        .code  (dec_code),
        .blank (dec_blank),
        .err   (dec_err)
    );

    // Slot selection, stability tracking and capture/frame decisions.
    always_comb begin
        an_ok        = 1'b1;
        an_idx       = 2'd0;
        cnt_nxt      = '0;
        case (an)
            4'b1110: an_idx = 2'd0;
            4'b1101: an_idx = 2'd1;
            4'b1011: an_idx = 2'd2;
            4'b0111: an_idx = 2'd3;
            default: an_ok  = 1'b0;
        endcase
        same = ({seg, an} == {samp_seg, samp_an});
        if (an_ok && same) begin
            cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        end
        // Armed flag keeps a long hold (including saturation) to a single capture.
        fire         = an_ok && same && armed && (cnt_nxt >= STABLE_THR);
        frame_load   = (cap_mask == 4'b1111);
        cap_mask_nxt = frame_load ? 4'b0000 : cap_mask;
        if (fire) begin
            cap_mask_nxt[an_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            samp_seg   <= '0;
            samp_an    <= '0;
            cnt        <= '0;
            armed      <= 1'b1;
            cap_mask   <= '0;
            slot_bcd   <= '0;
            slot_blank <= '0;
            slot_err   <= '0;
            bcd_out    <= '0;
            blank_mask <= '0;
            err_mask   <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            samp_seg <= seg;
            samp_an  <= an;
            cnt      <= cnt_nxt;
            if (cnt_nxt == '0) begin
                armed <= 1'b1;
            end else if (fire) begin
                armed <= 1'b0;
            end
            cap_mask <= cap_mask_nxt;
            if (fire) begin
                slot_bcd[{an_idx, 2'b00} +: 4] <= dec_code;
                slot_blank[an_idx]             <= dec_blank;
                slot_err[an_idx]               <= dec_err;
            end
            // A loading frame wins over a same-edge accept; unaccepted data is lost.
            if (frame_load) begin
                bcd_out    <= slot_bcd;
                blank_mask <= slot_blank;
                err_mask   <= slot_err;
                out_valid  <= 1'b1;
                if (out_valid && !out_ready) begin
                    overrun <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader: a run-length reference model is checked every
// cycle, and literal frame expectations pin the model.
module tb_seg7_scan_reader;

    localparam int unsigned S = 4;

    localparam logic [6:0] D0 = 7'b0000001;
    localparam logic [6:0] D1 = 7'b1001111;
    localparam logic [6:0] D2 = 7'b0010010;
    localparam logic [6:0] D3 = 7'b0000110;
    localparam logic [6:0] D4 = 7'b1001100;
    localparam logic [6:0] D5 = 7'b0100100;
    localparam logic [6:0] D6 = 7'b0100000;
    localparam logic [6:0] D7 = 7'b0001111;
    localparam logic [6:0] D8 = 7'b0000000;
    localparam logic [6:0] D9 = 7'b0000100;
    localparam logic [6:0] BLK = 7'b1111111;
    localparam logic [6:0] BAD = 7'b1111110;

    logic        clk;
    logic        rst;
    logic [0:6]  seg;
    logic [3:0]  an;
    logic [15:0] bcd_out;
    logic [3:0]  blank_mask;
    logic [3:0]  err_mask;
    logic        out_valid;
    logic        out_ready;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [15:0] lat_bcd;
    logic [3:0]  lat_bm;
    logic [3:0]  lat_em;

    seg7_scan_reader #(.STABLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg        (seg),
        .an         (an),
        .bcd_out    (bcd_out),
        .blank_mask (blank_mask),
        .err_mask   (err_mask),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state
    logic [10:0] m_prev;
    int          m_run;
    logic [3:0]  m_code [4];
    logic [3:0]  m_blank;
    logic [3:0]  m_err;
    logic [3:0]  m_mask;
    logic [15:0] m_bcd;
    logic [3:0]  m_bm;
    logic [3:0]  m_em;
    logic        m_valid;
    logic        m_ovr;

    function automatic void decode(input logic [6:0] p, output logic [3:0] c,
                                   output logic b, output logic e);
        logic [6:0] tbl [10] = '{D0, D1, D2, D3, D4, D5, D6, D7, D8, D9};
        c = 4'hE; b = 1'b0; e = 1'b1;
        if (p == BLK) begin
            c = 4'hF; b = 1'b1; e = 1'b0;
        end
        for (int d = 0; d < 10; d++) begin
            if (p == tbl[d]) begin
                c = 4'(d); e = 1'b0;
            end
        end
    endfunction

    function automatic bit one_low(input logic [3:0] a, output int idx);
        int n = 0;
        idx = 0;
        for (int i = 0; i < 4; i++) begin
            if (!a[i]) begin
                n++;
                idx = i;
            end
        end
        return n == 1;
    endfunction

    // A digit is taken when the same valid input has been seen on S+1 consecutive edges.
    always @(posedge clk) begin
        logic [10:0] cur;
        int          idx;
        bit          ok;
        logic [3:0]  c;
        logic        b, e;
        cur = {seg, an};
        if (rst) begin
            m_prev = '0; m_run = 0; m_mask = '0; m_blank = '0; m_err = '0;
            for (int i = 0; i < 4; i++) m_code[i] = '0;
            m_bcd = '0; m_bm = '0; m_em = '0; m_valid = 1'b0; m_ovr = 1'b0;
        end else begin
            ok = one_low(an, idx);
            if (ok && cur == m_prev) m_run++;
            else m_run = ok ? 1 : 0;
            m_prev = cur;
            if (m_mask == 4'hF) begin
                if (m_valid && !out_ready) m_ovr = 1'b1;
                m_bcd = {m_code[3], m_code[2], m_code[1], m_code[0]};
                m_bm = m_blank; m_em = m_err; m_valid = 1'b1; m_mask = '0;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (ok && m_run == int'(S) + 1) begin
                decode(seg, c, b, e);
                m_code[idx] = c; m_blank[idx] = b; m_err[idx] = e; m_mask[idx] = 1'b1;
            end
        end
    end

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        cmp("out_valid", 16'(out_valid), 16'(m_valid));
        cmp("bcd_out", bcd_out, m_bcd);
        cmp("blank_mask", 16'(blank_mask), 16'(m_bm));
        cmp("err_mask", 16'(err_mask), 16'(m_em));
        cmp("overrun", 16'(overrun), 16'(m_ovr));
        if (out_valid === 1'b1) begin
            pulses++;
            lat_bcd = bcd_out; lat_bm = blank_mask; lat_em = err_mask;
        end
    endtask

    task automatic drive(input logic r, input logic [6:0] s, input logic [3:0] a, input int n);
        for (int k = 0; k < n; k++) begin
            rst = r; seg = s; an = a;
            @(negedge clk);
            check_model();
        end
    endtask

    task automatic show(input int slot, input logic [6:0] s, input int n);
        logic [3:0] a;
        a = 4'b1111;
        a[slot] = 1'b0;
        drive(1'b0, s, a, n);
    endtask

    task automatic gap(input int n);
        drive(1'b0, BLK, 4'b1111, n);
    endtask

    initial begin
        rst = 1'b1; seg = D5; an = 4'b0101; out_ready = 1'b0;
        drive(1'b1, D5, 4'b0101, 1);
        drive(1'b1, D2, 4'b0000, 1);
        cmp("reset_state", {bcd_out[11:0], blank_mask ^ err_mask}, 16'h0000);
        cmp("reset_flags", {bcd_out[15:12], blank_mask, err_mask, 2'b00, out_valid, overrun}, 16'h0000);

        pulses = 0;
        gap(20);
        cmp("idle_no_valid", 16'(pulses), 16'd0);

        // Basic frame
        out_ready = 1'b1;
        pulses = 0;
        show(0, D3, 8); show(1, D5, 8); show(2, BLK, 8); show(3, D8, 8); gap(4);
        cmp("basic_pulses", 16'(pulses), 16'd1);
        cmp("basic_bcd", lat_bcd, 16'h8F53);
        cmp("basic_blank", 16'(lat_bm), 16'h0004);
        cmp("basic_err", 16'(lat_em), 16'h0000);

        // Glitch rejection
        pulses = 0;
        show(0, D1, 3); show(0, D0, 8); show(1, D1, 8); show(2, D2, 8); show(3, D4, 8); gap(4);
        cmp("glitch_pulses", 16'(pulses), 16'd1);
        cmp("glitch_bcd", lat_bcd, 16'h4210);

        // Exact-threshold hold is not enough, one more cycle is
        pulses = 0;
        gap(2); show(0, D7, 4); gap(2);
        show(1, D1, 8); show(2, D2, 8); show(3, D4, 8); gap(4);
        cmp("hold4_no_frame", 16'(pulses), 16'd0);
        show(0, D9, 5); gap(4);
        cmp("hold5_pulses", 16'(pulses), 16'd1);
        cmp("hold5_bcd", lat_bcd, 16'h4219);

        // Illegal pattern
        pulses = 0;
        show(0, D1, 8); show(1, D2, 8); show(2, BAD, 8); show(3, D3, 8); gap(4);
        cmp("illegal_pulses", 16'(pulses), 16'd1);
        cmp("illegal_bcd", lat_bcd, 16'h3E21);
        cmp("illegal_err", 16'(lat_em), 16'h0004);
        cmp("illegal_blank", 16'(lat_bm), 16'h0000);

        // Backpressure
        out_ready = 1'b0;
        show(0, D4, 8); show(1, D3, 8); show(2, D2, 8); show(3, D1, 8); gap(2);
        cmp("bp_first_bcd", bcd_out, 16'h1234);
        cmp("bp_first_state", {14'd0, out_valid, overrun}, 16'h0002);
        show(0, D8, 8); show(1, D7, 8); show(2, D6, 8); show(3, D5, 8); gap(2);
        cmp("bp_second_bcd", bcd_out, 16'h5678);
        cmp("bp_second_state", {14'd0, out_valid, overrun}, 16'h0003);
        out_ready = 1'b1;
        gap(1);
        out_ready = 1'b0;
        cmp("bp_accept_state", {14'd0, out_valid, overrun}, 16'h0001);
        gap(2);
        cmp("bp_sticky", 16'(overrun), 16'd1);

        // Reset mid-frame
        out_ready = 1'b1;
        show(0, D1, 8); show(1, D2, 8);
        drive(1'b1, BLK, 4'b1111, 1);
        cmp("midreset_clear", {bcd_out[7:0], 6'd0, out_valid, overrun}, 16'h0000);
        pulses = 0;
        show(2, D3, 8); show(3, D4, 8); gap(4);
        cmp("midreset_no_frame", 16'(pulses), 16'd0);
        show(0, D5, 8); show(1, D6, 8); gap(4);
        cmp("midreset_pulses", 16'(pulses), 16'd1);
        cmp("midreset_bcd", lat_bcd, 16'h4365);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
